// File: rtl/apb_cfg_master_if.sv
// Request/response port and APB bus of the config master, grouped as one bundle.
`timescale 1ns/1ps
interface apb_cfg_master_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic                      req_valid_i;
    logic                      req_ready_o;
    logic                      req_write_i;
    logic [APB_ADDR_WIDTH-1:0] req_addr_i;
    logic [31:0]               req_wdata_i;
    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [31:0]               rsp_rdata_o;
    logic                      rsp_err_o;
    logic                      rsp_timeout_o;
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );
endinterface

// File: rtl/apb_cfg_master.sv
// APB master: one valid/ready request becomes one SETUP+ACCESS transfer, with a
// wait-state timeout so a hung slave still produces an (error) response.
`timescale 1ns/1ps
module apb_cfg_master #(
    parameter int          APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                HCLK,
    input  logic                HRESET,
    apb_cfg_master_if.master    bus,
    output logic [1:0]          state_dbg
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 :
                           ($clog2(TIMEOUT_CYCLES + 1) > 32) ? 32 :
                           $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Handshakes: a request moves on valid&&ready at a rising edge; a response
    // is consumed on rsp_valid&&rsp_ready. Only one transfer is ever in flight.
    assign bus.req_ready_o = (state == IDLE) && !HRESET;
    assign state_dbg       = state;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state             <= IDLE;
            cnt               <= '0;
            bus.PSEL          <= 1'b0;
            bus.PENABLE       <= 1'b0;
            bus.PWRITE        <= 1'b0;
            bus.PADDR         <= '0;
            bus.PWDATA        <= '0;
            bus.rsp_valid_o   <= 1'b0;
            bus.rsp_rdata_o   <= '0;
            bus.rsp_err_o     <= 1'b0;
            bus.rsp_timeout_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        bus.PADDR  <= bus.req_addr_i[APB_ADDR_WIDTH-1:0];
                        bus.PWDATA <= bus.req_wdata_i;
                        bus.PWRITE <= bus.req_write_i;
                        bus.PSEL   <= 1'b1;
                        cnt        <= '0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    bus.PENABLE <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        bus.rsp_rdata_o   <= bus.PWRITE ? 32'd0 : bus.PRDATA;
                        bus.rsp_err_o     <= bus.PSLVERR;
                        bus.rsp_timeout_o <= 1'b0;
                        bus.rsp_valid_o   <= 1'b1;
                        bus.PSEL          <= 1'b0;
                        bus.PENABLE       <= 1'b0;
                        state             <= RESP;
                    end else if (TO_EN && cnt == TO_LAST) begin
                        // cnt counts earlier stalled cycles, so this one is the limit
                        bus.rsp_rdata_o   <= 32'd0;
                        bus.rsp_err_o     <= 1'b1;
                        bus.rsp_timeout_o <= 1'b1;
                        bus.rsp_valid_o   <= 1'b1;
                        bus.PSEL          <= 1'b0;
                        bus.PENABLE       <= 1'b0;
                        state             <= RESP;
                    end else if (~&cnt) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        bus.rsp_valid_o <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_cfg_master.sv
// Bench for apb_cfg_master: scenario tasks with a response scoreboard queue.
`timescale 1ns/1ps
module tb_apb_cfg_master;
    logic       HCLK;
    logic       HRESET;
    logic [1:0] state_dbg;
    int         vectors;
    int         miscompares;
    logic [33:0] exp_q[$];

    apb_cfg_master_if #(.APB_ADDR_WIDTH(12)) bus();

    apb_cfg_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(4)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Pop the next expected response once the DUT presents one, then consume it.
    task automatic sb_consume(input string name);
        int n;
        logic [33:0] e;
        n = 0;
        while (bus.rsp_valid_o !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
        vectors++;
        if (bus.rsp_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s rsp_valid: got %b want 1 (timed out)", name, bus.rsp_valid_o);
        end else if ({bus.rsp_timeout_o, bus.rsp_err_o, bus.rsp_rdata_o} !== e) begin
            miscompares++;
            $display("FAIL %s rsp {timeout,err,rdata}: got %h want %h", name,
                     {bus.rsp_timeout_o, bus.rsp_err_o, bus.rsp_rdata_o}, e);
        end
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        vectors++;
        if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s after handshake {rsp_valid,req_ready}: got %b%b want 01",
                     name, bus.rsp_valid_o, bus.req_ready_o);
        end
    endtask

    // Issue a request from IDLE; returns in the SETUP cycle (T+1) after checking it.
    task automatic do_req(input logic w, input logic [11:0] a, input logic [31:0] d,
                          input string name);
        vectors++;
        if (bus.req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s req_ready: got %b want 1", name, bus.req_ready_o);
        end
        bus.req_valid_i = 1'b1;
        bus.req_write_i = w;
        bus.req_addr_i  = a;
        bus.req_wdata_i = d;
        tick();
        bus.req_valid_i = 1'b0;
        vectors++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA} !== {1'b1, 1'b0, w, a, d}) begin
            miscompares++;
            $display("FAIL %s setup {sel,en,wr,addr,wdata}: got %h want %h", name,
                     {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA},
                     {1'b1, 1'b0, w, a, d});
        end
    endtask

    // Full transfer with ws stalled ACCESS cycles before PREADY.
    task automatic xfer(input logic w, input logic [11:0] a, input logic [31:0] d,
                        input int ws, input logic err, input logic [31:0] rd,
                        input string name);
        bus.PREADY = 1'b0;
        do_req(w, a, d, name);
        tick();
        for (int i = 0; i <= ws; i++) begin
            vectors++;
            if ({bus.PSEL, bus.PENABLE, bus.PADDR, bus.rsp_valid_o} !== {1'b1, 1'b1, a, 1'b0}) begin
                miscompares++;
                $display("FAIL %s access cyc %0d {sel,en,addr,rsp_valid}: got %h want %h", name, i,
                         {bus.PSEL, bus.PENABLE, bus.PADDR, bus.rsp_valid_o}, {1'b1, 1'b1, a, 1'b0});
            end
            if (i < ws) tick();
        end
        bus.PREADY  = 1'b1;
        bus.PSLVERR = err;
        bus.PRDATA  = rd;
        exp_q.push_back({1'b0, err, w ? 32'd0 : rd});
        tick();
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        vectors++;
        if ({bus.rsp_valid_o, bus.PSEL, bus.PENABLE} !== 3'b100) begin
            miscompares++;
            $display("FAIL %s resp cycle {rsp_valid,sel,en}: got %b want 100", name,
                     {bus.rsp_valid_o, bus.PSEL, bus.PENABLE});
        end
        sb_consume(name);
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.rsp_valid_o,
             bus.rsp_rdata_o, bus.rsp_err_o, bus.rsp_timeout_o, bus.req_ready_o, state_dbg} !== '0) begin
            miscompares++;
            $display("FAIL reset outputs: got nonzero, sel=%b en=%b addr=%h rsp_valid=%b req_ready=%b state=%0d want all 0",
                     bus.PSEL, bus.PENABLE, bus.PADDR, bus.rsp_valid_o, bus.req_ready_o, state_dbg);
        end
        HRESET = 1'b0;
        tick();
        vectors++;
        if (bus.req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset release req_ready: got %b want 1", bus.req_ready_o);
        end
    endtask

    task automatic test_write();
        xfer(1'b1, 12'h008, 32'h0000_1000, 0, 1'b0, 32'hFFFF_FFFF, "write_0ws");
    endtask

    task automatic test_read_wait();
        xfer(1'b0, 12'h010, 32'h0, 3, 1'b0, 32'h0000_0104, "read_3ws");
    endtask

    task automatic test_slverr();
        xfer(1'b1, 12'h0C4, 32'hCAFE_0001, 1, 1'b1, 32'h0, "slverr_write");
        xfer(1'b0, 12'h0C8, 32'h0, 0, 1'b0, 32'h1234_5678, "after_slverr_read");
    endtask

    task automatic test_timeout();
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'hDEAD_BEEF;
        do_req(1'b0, 12'h040, 32'h0, "timeout");
        exp_q.push_back({1'b1, 1'b1, 32'd0});
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({bus.PSEL, bus.PENABLE, bus.rsp_valid_o} !== 3'b110) begin
                miscompares++;
                $display("FAIL timeout stall cyc %0d {sel,en,rsp_valid}: got %b want 110", i,
                         {bus.PSEL, bus.PENABLE, bus.rsp_valid_o});
            end
        end
        tick();
        vectors++;
        if ({bus.PSEL, bus.PENABLE, bus.rsp_valid_o} !== 3'b001) begin
            miscompares++;
            $display("FAIL timeout abort {sel,en,rsp_valid}: got %b want 001",
                     {bus.PSEL, bus.PENABLE, bus.rsp_valid_o});
        end
        sb_consume("timeout");
    endtask

    task automatic test_backpressure();
        bus.PREADY = 1'b0;
        do_req(1'b0, 12'h020, 32'h0, "backpressure");
        tick();
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'hA5A5_0F0F;
        exp_q.push_back({1'b0, 1'b0, 32'hA5A5_0F0F});
        tick();
        bus.PREADY      = 1'b0;
        bus.PRDATA      = 32'h0;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 12'h7FF;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({bus.rsp_valid_o, bus.rsp_timeout_o, bus.rsp_err_o, bus.rsp_rdata_o,
                 bus.req_ready_o, bus.PSEL} !== {1'b1, 1'b0, 1'b0, 32'hA5A5_0F0F, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL backpressure hold cyc %0d: got valid=%b rdata=%h req_ready=%b sel=%b want 1 a5a50f0f 0 0",
                         i, bus.rsp_valid_o, bus.rsp_rdata_o, bus.req_ready_o, bus.PSEL);
            end
            tick();
        end
        bus.req_valid_i = 1'b0;
        sb_consume("backpressure");
    endtask

    task automatic test_reset_mid();
        bus.PREADY = 1'b0;
        do_req(1'b1, 12'h030, 32'h0BAD_F00D, "reset_mid");
        tick();
        HRESET = 1'b1;
        tick();
        vectors++;
        if ({bus.PSEL, bus.PENABLE, bus.rsp_valid_o, bus.req_ready_o, state_dbg} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_mid in reset {sel,en,rsp_valid,req_ready,state}: got %b want 000000",
                     {bus.PSEL, bus.PENABLE, bus.rsp_valid_o, bus.req_ready_o, state_dbg});
        end
        HRESET     = 1'b0;
        bus.PREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({bus.PSEL, bus.rsp_valid_o, bus.req_ready_o, state_dbg} !== 5'b00100) begin
                miscompares++;
                $display("FAIL reset_mid after cyc %0d {sel,rsp_valid,req_ready,state}: got %b want 00100",
                         i, {bus.PSEL, bus.rsp_valid_o, bus.req_ready_o, state_dbg});
            end
        end
        bus.PREADY = 1'b0;
    endtask

    task automatic test_back_to_back();
        int k, last, cyc;
        logic [33:0] e;
        k = 0; last = -1;
        bus.rsp_ready_i = 1'b1;
        bus.PREADY      = 1'b1;
        bus.PRDATA      = 32'h5A5A_0001;
        bus.req_valid_i = 1'b1;
        bus.req_write_i = 1'b1;
        bus.req_addr_i  = 12'h100;
        bus.req_wdata_i = 32'h1;
        for (cyc = 0; cyc < 20; cyc++) begin
            if (bus.rsp_valid_o === 1'b1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
                vectors++;
                if ({bus.rsp_timeout_o, bus.rsp_err_o, bus.rsp_rdata_o} !== e) begin
                    miscompares++;
                    $display("FAIL b2b rsp cyc %0d: got %h want %h", cyc,
                             {bus.rsp_timeout_o, bus.rsp_err_o, bus.rsp_rdata_o}, e);
                end
            end
            if (bus.req_valid_i && bus.req_ready_o === 1'b1) begin
                if (last >= 0) begin
                    vectors++;
                    if (cyc - last != 4) begin
                        miscompares++;
                        $display("FAIL b2b spacing: got %0d cycles want 4", cyc - last);
                    end
                end
                last = cyc;
                exp_q.push_back({1'b0, 1'b0, bus.req_write_i ? 32'd0 : 32'h5A5A_0001});
                tick();
                k++;
                bus.req_valid_i = (k < 4);
                bus.req_write_i = ~bus.req_write_i;
                bus.req_addr_i  = bus.req_addr_i + 12'h4;
            end else begin
                tick();
            end
        end
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
        bus.PREADY      = 1'b0;
        vectors++;
        if (k != 4) begin
            miscompares++;
            $display("FAIL b2b accepted count: got %0d want 4", k);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            xfer(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), $urandom,
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom, "random");
        end
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        HRESET          = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.rsp_ready_i = 1'b0;
        bus.PRDATA      = '0;
        bus.PREADY      = 1'b0;
        bus.PSLVERR     = 1'b0;

        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: got %0d left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
